// File: rtl/btle_rx_pdu_deframer.sv
// BLE 1M receive PDU deframer: de-whitens the bits that follow an access-address hit,
// emits header and payload octets, and checks the trailing 24-bit CRC.
module btle_rx_pdu_deframer #(
  parameter int unsigned MAX_PAYLOAD_LEN = 255,
  parameter logic [23:0] CRC_POLY        = 24'h00065B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phy_bit_i,
  input  logic        bit_valid_i,
  input  logic        hit_flag_i,
  input  logic [5:0]  channel_number_i,
  input  logic [23:0] crc_init_i,
  output logic [7:0]  octet_o,
  output logic        octet_valid_o,
  output logic [8:0]  octet_idx_o,
  output logic [7:0]  payload_len_o,
  output logic        payload_len_valid_o,
  output logic        info_valid_o,
  output logic        crc_ok_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, HDR, PLD, CRC, ABORT, DONE} state_e;

  state_e      state_q, state_d;
  logic [6:0]  whiten_q, whiten_d;
  logic [23:0] crc_q, crc_d;
  logic [7:0]  shift_q, shift_d;
  logic [10:0] bitCnt_q, bitCnt_d;
  logic [8:0]  octetCnt_q, octetCnt_d;
  logic [7:0]  octet_q, octet_d;
  logic        octetValid_q, octetValid_d;
  logic [8:0]  octetIdx_q, octetIdx_d;
  logic [7:0]  payloadLen_q, payloadLen_d;
  logic        lenValid_q, lenValid_d;
  logic        crcOk_q, crcOk_d;
  logic        crcErr_q, crcErr_d;

  logic        consume;
  logic        dBit;
  logic        crcBitErr;
  logic [7:0]  newByte;
  logic [6:0]  whitenNext;
  logic [23:0] crcNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      whiten_q     <= '0;
      crc_q        <= '0;
      shift_q      <= '0;
      bitCnt_q     <= '0;
      octetCnt_q   <= '0;
      octet_q      <= '0;
      octetValid_q <= 1'b0;
      octetIdx_q   <= '0;
      payloadLen_q <= '0;
      lenValid_q   <= 1'b0;
      crcOk_q      <= 1'b0;
      crcErr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      whiten_q     <= whiten_d;
      crc_q        <= crc_d;
      shift_q      <= shift_d;
      bitCnt_q     <= bitCnt_d;
      octetCnt_q   <= octetCnt_d;
      octet_q      <= octet_d;
      octetValid_q <= octetValid_d;
      octetIdx_q   <= octetIdx_d;
      payloadLen_q <= payloadLen_d;
      lenValid_q   <= lenValid_d;
      crcOk_q      <= crcOk_d;
      crcErr_q     <= crcErr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    whiten_d     = whiten_q;
    crc_d        = crc_q;
    shift_d      = shift_q;
    bitCnt_d     = bitCnt_q;
    octetCnt_d   = octetCnt_q;
    octet_d      = octet_q;
    octetValid_d = 1'b0;
    octetIdx_d   = octetIdx_q;
    payloadLen_d = payloadLen_q;
    lenValid_d   = 1'b0;
    crcOk_d      = crcOk_q;
    crcErr_d     = crcErr_q;

    consume    = bit_valid_i && (state_q == HDR || state_q == PLD || state_q == CRC);
    dBit       = phy_bit_i ^ whiten_q[6];
    newByte    = {dBit, shift_q[7:1]};
    whitenNext = {whiten_q[5:0], whiten_q[6]};
    whitenNext[4] = whiten_q[3] ^ whiten_q[6];
    crcNext    = {crc_q[22:0], 1'b0} ^ ((crc_q[23] ^ dBit) ? CRC_POLY : 24'd0);
    crcBitErr  = dBit ^ crc_q[5'd23 - bitCnt_q[4:0]];

    unique case (state_q)
      IDLE: begin
        if (hit_flag_i) begin
          state_d      = HDR;
          whiten_d     = {channel_number_i[0], channel_number_i[1], channel_number_i[2],
                          channel_number_i[3], channel_number_i[4], channel_number_i[5], 1'b1};
          crc_d        = crc_init_i;
          bitCnt_d     = '0;
          octetCnt_d   = '0;
          payloadLen_d = '0;
          crcOk_d      = 1'b0;
          crcErr_d     = 1'b0;
        end
      end
      HDR, PLD: begin
        if (consume) begin
          whiten_d = whitenNext;
          crc_d    = crcNext;
          shift_d  = newByte;
          bitCnt_d = bitCnt_q + 11'd1;
          if (bitCnt_q[2:0] == 3'd7) begin
            octet_d      = newByte;
            octetValid_d = 1'b1;
            octetIdx_d   = octetCnt_q;
            octetCnt_d   = octetCnt_q + 9'd1;
          end
          // The second header byte is the length and decides where the packet goes next.
          if (state_q == HDR && bitCnt_q == 11'd15) begin
            payloadLen_d = newByte;
            lenValid_d   = 1'b1;
            bitCnt_d     = '0;
            if (newByte == 8'd0) begin
              state_d = CRC;
            end else if (32'(newByte) > MAX_PAYLOAD_LEN) begin
              state_d = ABORT;
            end else begin
              state_d = PLD;
            end
          end
          if (state_q == PLD && bitCnt_q == ({payloadLen_q, 3'b000} - 11'd1)) begin
            state_d  = CRC;
            bitCnt_d = '0;
          end
        end
      end
      CRC: begin
        if (consume) begin
          whiten_d = whitenNext;
          bitCnt_d = bitCnt_q + 11'd1;
          if (crcBitErr) begin
            crcErr_d = 1'b1;
          end
          if (bitCnt_q == 11'd23) begin
            state_d = DONE;
            crcOk_d = !(crcErr_q || crcBitErr);
          end
        end
      end
      // One spacer cycle so an oversize length reports a cycle after its length strobe.
      ABORT: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign octet_o             = octet_q;
  assign octet_valid_o       = octetValid_q;
  assign octet_idx_o         = octetIdx_q;
  assign payload_len_o       = payloadLen_q;
  assign payload_len_valid_o = lenValid_q;
  assign info_valid_o        = (state_q == DONE);
  assign crc_ok_o            = crcOk_q;
  assign busy_o              = (state_q != IDLE);

endmodule

// File: tb/tb_btle_rx_pdu_deframer.sv
// Self-checking bench for btle_rx_pdu_deframer: a byte-level packet model builds the
// whitened bit stream and the expected octets/CRC verdict, one monitor checks them.
module tb_btle_rx_pdu_deframer;
  localparam int          MAX_LEN = 37;
  localparam logic [23:0] POLY    = 24'h00065B;

  typedef struct {
    logic [7:0] data;
    int         idx;
  } octExp_t;

  typedef struct {
    bit crcOk;
    bit isAbort;
    int doneNeg;
  } pktExp_t;

  logic        clk = 1'b0;
  logic        rst, phyBit, bitValid, hitFlag;
  logic [5:0]  chan;
  logic [23:0] crcInit;
  logic [7:0]  octet, payloadLen;
  logic [8:0]  octetIdx;
  logic        octetValid, payloadLenValid, infoValid, crcOk, busy;

  int      checks = 0;
  int      errors = 0;
  int      negCnt = 0;
  int      lastPlvNeg = -10;
  int      curOctCount = 0;
  bit      curAbort = 1'b0;
  bit      wireQ[$];
  octExp_t octQ[$];
  int      octTimeQ[$];
  pktExp_t pktQ[$];

  btle_rx_pdu_deframer #(.MAX_PAYLOAD_LEN(MAX_LEN), .CRC_POLY(POLY)) dut (
    .clk(clk), .rst(rst), .phy_bit_i(phyBit), .bit_valid_i(bitValid), .hit_flag_i(hitFlag),
    .channel_number_i(chan), .crc_init_i(crcInit), .octet_o(octet), .octet_valid_o(octetValid),
    .octet_idx_o(octetIdx), .payload_len_o(payloadLen), .payload_len_valid_o(payloadLenValid),
    .info_valid_o(infoValid), .crc_ok_o(crcOk), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of input drive, changed 2 ns after the rising edge.
  task automatic applyStimulus(input bit r, input bit h, input bit bv, input bit b,
                               input logic [5:0] c, input logic [23:0] ini);
    @(posedge clk);
    #2;
    rst = r; hitFlag = h; bitValid = bv; phyBit = b; chan = c; crcInit = ini;
  endtask

  function automatic logic [6:0] lfsrSeed(input logic [5:0] c);
    return {c[0], c[1], c[2], c[3], c[4], c[5], 1'b1};
  endfunction

  function automatic logic [6:0] lfsrStep(input logic [6:0] s);
    logic [6:0] n;
    n    = {s[5:0], s[6]};
    n[4] = s[3] ^ s[6];
    return n;
  endfunction

  function automatic logic [15:0] whiten16(input logic [5:0] c);
    logic [6:0]  s;
    logic [15:0] r;
    s = lfsrSeed(c);
    for (int i = 0; i < 16; i++) begin
      r[i] = s[6];
      s    = lfsrStep(s);
    end
    return r;
  endfunction

  function automatic logic [23:0] crcByte(input logic [23:0] c, input logic [7:0] b);
    logic [23:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = {r[22:0], 1'b0} ^ ((r[23] ^ b[i]) ? POLY : 24'd0);
    end
    return r;
  endfunction

  // Builds the on-air bits for one packet plus the octets and verdict a receiver must report.
  task automatic buildPacket(input logic [5:0] c, input logic [23:0] ini, input logic [7:0] hdr0,
                             input logic [7:0] lenByte, input int flipAt, input logic [7:0] seed);
    logic [7:0]  tx[$];
    bit          plain[$];
    logic [23:0] txCrc, rxCrc, rxField;
    logic [7:0]  v;
    logic [6:0]  s;
    bit          ab;
    octExp_t     e;
    pktExp_t     p;
    ab = (int'(lenByte) > MAX_LEN);
    tx.push_back(hdr0);
    tx.push_back(lenByte);
    if (!ab) for (int i = 0; i < int'(lenByte); i++) tx.push_back(seed + 8'(i * 29));
    txCrc = ini;
    foreach (tx[i]) txCrc = crcByte(txCrc, tx[i]);
    foreach (tx[i]) for (int b = 0; b < 8; b++) plain.push_back(tx[i][b]);
    for (int k = 0; k < 24; k++) plain.push_back(txCrc[23-k]);
    if (flipAt >= 0) plain[flipAt] = !plain[flipAt];
    rxCrc = ini;
    for (int i = 0; i < tx.size(); i++) begin
      for (int b = 0; b < 8; b++) v[b] = plain[8*i+b];
      e.data = v;
      e.idx  = i;
      octQ.push_back(e);
      rxCrc = crcByte(rxCrc, v);
    end
    for (int k = 0; k < 24; k++) rxField[23-k] = plain[8*tx.size()+k];
    p.crcOk   = !ab && (rxCrc == rxField);
    p.isAbort = ab;
    p.doneNeg = -1;
    pktQ.push_back(p);
    curOctCount = tx.size();
    curAbort    = ab;
    wireQ.delete();
    s = lfsrSeed(c);
    foreach (plain[j]) begin
      wireQ.push_back(plain[j] ^ s[6]);
      s = lfsrStep(s);
    end
  endtask

  // hitMode: 0 plain hit, 1 hit with an unconsumed bit_valid, 2 decoy hit then real hit.
  task automatic sendPacket(input logic [5:0] c, input logic [23:0] ini, input int hitMode,
                            input int midHitBit, input int rstAfterBits);
    int gap;
    if (hitMode == 2) begin
      applyStimulus(0, 1, 0, 0, c ^ 6'h15, ~ini);
      #4 checkOutput("busy in DONE cycle", 32'(busy), 1);
    end
    applyStimulus(0, 1, (hitMode == 1), 1, c, ini);
    #4 checkOutput("busy in accept cycle", 32'(busy), 0);
    applyStimulus(0, 0, 0, 0, c, ini);
    #4 checkOutput("busy after accept", 32'(busy), 1);
    checkOutput("crc_ok cleared on hit", 32'(crcOk), 0);
    for (int j = 0; j < wireQ.size(); j++) begin
      gap = (j % 61 == 17) ? 20 : (j * 5 + 3) % 4;
      for (int g = 0; g < gap; g++) applyStimulus(0, 0, 0, !wireQ[j], c ^ 6'h2A, ~ini);
      applyStimulus(0, (j == midHitBit), 1, wireQ[j], c ^ 6'h2A, ~ini);
      if (j % 8 == 7 && j / 8 < curOctCount) octTimeQ.push_back(negCnt + 2);
      if (j == wireQ.size() - 1 && !curAbort) pktQ[pktQ.size()-1].doneNeg = negCnt + 2;
      if (j + 1 == rstAfterBits) begin
        applyStimulus(1, 0, 0, 0, c, ini);
        applyStimulus(0, 0, 0, 0, c, ini);
        #4;
        checkOutput("outputs after rst", {2'b00, octet, octetValid, octetIdx, payloadLen,
                    payloadLenValid, infoValid, crcOk, busy}, 0);
        checkOutput("octets before rst", (octQ.size() > 0) ? 32'(octQ[0].idx) : 32'hFFFF, 4);
        checkOutput("octet timing pending at rst", 32'(octTimeQ.size()), 0);
        octQ.delete();
        octTimeQ.delete();
        void'(pktQ.pop_back());
        return;
      end
    end
  endtask

  task automatic finishPacket(input logic [7:0] expLen, input bit expCrc);
    repeat (6) applyStimulus(0, 0, 0, 0, 6'd0, 24'd0);
    #4;
    checkOutput("busy idle", 32'(busy), 0);
    checkOutput("crc_ok held", 32'(crcOk), 32'(expCrc));
    checkOutput("payload_len held", 32'(payloadLen), 32'(expLen));
    checkOutput("octets missing", 32'(octQ.size()), 0);
    checkOutput("info_valid missing", 32'(pktQ.size()), 0);
    checkOutput("octet timing missing", 32'(octTimeQ.size()), 0);
  endtask

  always @(negedge clk) begin : monitor
    octExp_t e;
    pktExp_t p;
    negCnt++;
    if (octetValid) begin
      if (octQ.size() == 0) begin
        checkOutput("unexpected octet", 1, 0);
      end else begin
        e = octQ.pop_front();
        checkOutput("octet", 32'(octet), 32'(e.data));
        checkOutput("octet_idx", 32'(octetIdx), 32'(e.idx));
        checkOutput("payload_len_valid", 32'(payloadLenValid), 32'(e.idx == 1));
        if (e.idx == 1) checkOutput("payload_len", 32'(payloadLen), 32'(e.data));
        checkOutput("octet timing", 32'(negCnt), (octTimeQ.size() > 0) ? 32'(octTimeQ.pop_front()) : 32'hFFFF);
      end
    end else begin
      checkOutput("payload_len_valid stray", 32'(payloadLenValid), 0);
    end
    if (payloadLenValid) lastPlvNeg = negCnt;
    if (infoValid) begin
      if (pktQ.size() == 0) begin
        checkOutput("unexpected info_valid", 1, 0);
      end else begin
        p = pktQ.pop_front();
        checkOutput("crc_ok", 32'(crcOk), 32'(p.crcOk));
        checkOutput("info timing", 32'(negCnt), p.isAbort ? 32'(lastPlvNeg + 1) : 32'(p.doneNeg));
        checkOutput("busy with info", 32'(busy), 1);
      end
    end
  end

  initial begin
    octExp_t e;
    pktExp_t p;
    rst = 1'b1; hitFlag = 1'b0; bitValid = 1'b0; phyBit = 1'b0; chan = '0; crcInit = '0;
    repeat (3) applyStimulus(1, 0, 0, 0, 6'd0, 24'd0);
    #4 checkOutput("reset outputs", {2'b00, octet, octetValid, octetIdx, payloadLen,
                   payloadLenValid, infoValid, crcOk, busy}, 0);

    checkOutput("model whitening ch37", 32'(whiten16(6'd37)), 32'h0000D28D);
    checkOutput("model crc of 0x01", 32'(crcByte(24'd0, 8'h01)), 32'h00032D80);

    // ADV_IND, length 6, clean then with one payload bit inverted
    buildPacket(6'd37, 24'h555555, 8'h40, 8'd6, -1, 8'hA0);
    sendPacket(6'd37, 24'h555555, 1, -1, -1);
    finishPacket(8'd6, 1'b1);
    buildPacket(6'd37, 24'h555555, 8'h40, 8'd6, 35, 8'hA0);
    sendPacket(6'd37, 24'h555555, 0, -1, -1);
    finishPacket(8'd6, 1'b0);

    // Empty PDU straight into the CRC field
    buildPacket(6'd5, 24'h123456, 8'h01, 8'd0, -1, 8'h00);
    sendPacket(6'd5, 24'h123456, 0, -1, -1);
    finishPacket(8'd0, 1'b1);

    // Oversize length aborts after the header
    buildPacket(6'd12, 24'h0ABCDE, 8'h02, 8'd200, -1, 8'h00);
    sendPacket(6'd12, 24'h0ABCDE, 0, -1, -1);
    finishPacket(8'd200, 1'b0);

    // All-zero air bits on ch37 de-whiten to the raw whitening sequence 8D D2 (length 210)
    e.data = 8'h8D; e.idx = 0; octQ.push_back(e);
    e.data = 8'hD2; e.idx = 1; octQ.push_back(e);
    p.crcOk = 1'b0; p.isAbort = 1'b1; p.doneNeg = -1; pktQ.push_back(p);
    curOctCount = 2; curAbort = 1'b1;
    wireQ.delete();
    for (int i = 0; i < 40; i++) wireQ.push_back(1'b0);
    sendPacket(6'd37, 24'h000000, 0, -1, -1);
    finishPacket(8'hD2, 1'b0);

    // Largest accepted length
    buildPacket(6'd39, 24'hFEDCBA, 8'h40, 8'd37, -1, 8'h11);
    sendPacket(6'd39, 24'hFEDCBA, 0, -1, -1);
    finishPacket(8'd37, 1'b1);

    // Hit during payload and in DONE are ignored; hit one cycle later starts the next packet
    buildPacket(6'd17, 24'h13579B, 8'h42, 8'd3, -1, 8'h5C);
    sendPacket(6'd17, 24'h13579B, 0, 21, -1);
    buildPacket(6'd22, 24'h2468AC, 8'h40, 8'd4, -1, 8'h33);
    sendPacket(6'd22, 24'h2468AC, 2, -1, -1);
    finishPacket(8'd4, 1'b1);

    // Reset mid-payload, then a clean packet
    buildPacket(6'd8, 24'h600D00, 8'h40, 8'd10, -1, 8'h77);
    sendPacket(6'd8, 24'h600D00, 0, -1, 35);
    buildPacket(6'd8, 24'h600D00, 8'h40, 8'd10, -1, 8'h77);
    sendPacket(6'd8, 24'h600D00, 0, -1, -1);
    finishPacket(8'd10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
